// File: rtl/tlul_fetch_host.sv
// tlul_fetch_host: core fetch req/gnt to in-order TL-UL Get host; ports clock, reset(n), req_i/addr_i/gnt_o, rvalid_o/rdata_o/err_o, tl_o/tl_i, flush_i only with TLUL_FETCH_FLUSH_EN
package tlul_pkg;
  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic [15:0] a_user;
    logic        d_ready;
  } tl_h2d_t;
  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic [15:0] d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
endpackage

module tlul_fetch_host #(
  parameter int AW = 32,
  parameter int Outstanding = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_i,
  input  logic [AW-1:0]     addr_i,
  output logic              gnt_o,
  output logic              rvalid_o,
  output logic [31:0]       rdata_o,
  output logic              err_o,
`ifdef TLUL_FETCH_FLUSH_EN
  input  logic              flush_i,
`endif
  output tlul_pkg::tl_h2d_t tl_o,
  input  tlul_pkg::tl_d2h_t tl_i
);
  localparam int SrcW = Outstanding > 1 ? $clog2(Outstanding) : 1;
  localparam logic [SrcW:0] max_pend = (SrcW+1)'(Outstanding);
  logic [SrcW-1:0] r_issue, r_expect;
  logic [SrcW:0]   r_pending;
  logic            r_rvalid, r_err;
  logic [31:0]     r_rdata;
  logic            w_a_valid, w_a_hs, w_d_take, w_drop, w_deliver, w_err;
  function automatic logic [SrcW-1:0] nxt(input logic [SrcW-1:0] p);
    return p == SrcW'(Outstanding-1) ? '0 : p + 1'b1;
  endfunction
  assign w_a_valid = req_i && (r_pending < max_pend);
  assign w_a_hs    = w_a_valid && tl_i.a_ready;
  assign w_d_take  = tl_i.d_valid && (r_pending != '0);
  assign w_deliver = w_d_take && !w_drop;
  assign w_err     = tl_i.d_error || (tl_i.d_opcode != 3'd1) || (tl_i.d_source != 8'(r_expect));
  assign gnt_o     = w_a_hs;
  assign rvalid_o  = r_rvalid;
  assign rdata_o   = r_rdata;
  assign err_o     = r_err;
  always_comb begin
    tl_o           = '0;
    tl_o.a_valid   = w_a_valid;
    tl_o.a_opcode  = 3'd4;
    tl_o.a_size    = 2'd2;
    tl_o.a_source  = 8'(r_issue);
    tl_o.a_address = 32'({addr_i[AW-1:2], 2'b00});
    tl_o.a_mask    = 4'hF;
    tl_o.d_ready   = 1'b1;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_issue   <= '0;
      r_expect  <= '0;
      r_pending <= '0;
      r_rvalid  <= 1'b0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
    end else begin
      if (w_a_hs) r_issue <= nxt(r_issue);
      if (w_d_take) r_expect <= nxt(r_expect);
      r_pending <= r_pending + {{SrcW{1'b0}}, w_a_hs} - {{SrcW{1'b0}}, w_d_take};
      r_rvalid  <= w_deliver;
      if (w_deliver) r_rdata <= tl_i.d_data;
      if (w_deliver) r_err <= w_err;
    end
  end
`ifdef TLUL_FETCH_FLUSH_EN
  logic [SrcW:0] r_discard;
  assign w_drop = w_d_take && (flush_i || r_discard != '0);
  always_ff @(posedge clock) begin
    if (!reset) r_discard <= '0;
    else if (flush_i) r_discard <= r_pending - {{SrcW{1'b0}}, w_d_take};
    else if (w_d_take && r_discard != '0) r_discard <= r_discard - 1'b1;
  end
`else
  assign w_drop = 1'b0;
`endif
  logic w_unused;
  assign w_unused = ^{addr_i[1:0], tl_i.d_param, tl_i.d_size, tl_i.d_sink, tl_i.d_user};
endmodule

// File: tb/tb_tlul_fetch_host.sv
// tb_tlul_fetch_host: directed scoreboard bench for tlul_fetch_host
module tb_tlul_fetch_host;
  logic              clock = 1'b0;
  logic              reset;
  logic              req_i;
  logic [31:0]       addr_i;
  logic              gnt_o, rvalid_o, err_o;
  logic [31:0]       rdata_o;
`ifdef TLUL_FETCH_FLUSH_EN
  logic              flush_i = 1'b0;
`endif
  tlul_pkg::tl_h2d_t tl_o;
  tlul_pkg::tl_d2h_t tl_i;
  int n_vec = 0, n_miss = 0;
  logic [32:0] exp_q[$];
  tlul_fetch_host dut (
    .clock(clock), .reset(reset), .req_i(req_i), .addr_i(addr_i), .gnt_o(gnt_o),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
`ifdef TLUL_FETCH_FLUSH_EN
    .flush_i(flush_i),
`endif
    .tl_o(tl_o), .tl_i(tl_i)
  );
  always #5 clock = ~clock;
  always @(negedge clock) begin
    if (rvalid_o) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL unexpected_rvalid: got rdata=%h err=%b, expected no response", rdata_o, err_o);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        if ({err_o, rdata_o} !== e) begin
          n_miss++;
          $display("FAIL response: got err=%b rdata=%h, expected err=%b rdata=%h", err_o, rdata_o, e[32], e[31:0]);
        end
      end
    end
  end
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask
  task automatic set_d(input logic [7:0] src, input logic [31:0] data, input logic [2:0] op, input logic de);
    tl_i.d_valid  = 1'b1;
    tl_i.d_source = src;
    tl_i.d_data   = data;
    tl_i.d_opcode = op;
    tl_i.d_error  = de;
  endtask
  task automatic clr_d;
    tl_i.d_valid  = 1'b0;
    tl_i.d_opcode = 3'd1;
    tl_i.d_error  = 1'b0;
  endtask
  task automatic dsend(input logic [7:0] src, input logic [31:0] data, input logic [2:0] op,
                       input logic de, input logic push, input logic ee);
    set_d(src, data, op, de);
    if (push) exp_q.push_back({ee, data});
    tick;
    clr_d;
  endtask
  task automatic fetch(input string name, input logic [31:0] a, input logic [7:0] src);
    req_i = 1'b1;
    addr_i = a;
    #3;
    chk({name, "_gnt"}, 64'(gnt_o), 64'd1);
    chk({name, "_src"}, 64'(tl_o.a_source), 64'(src));
    tick;
    req_i = 1'b0;
  endtask
  initial begin
    reset = 1'b0;
    req_i = 1'b0;
    addr_i = '0;
    tl_i = '0;
    tl_i.a_ready = 1'b1;
    tl_i.d_opcode = 3'd1;
    repeat (2) tick;
    #3;
    chk("rst_rvalid", 64'(rvalid_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_rdata", 64'(rdata_o), 64'd0);
    chk("rst_avalid", 64'(tl_o.a_valid), 64'd0);
    tick;
    reset = 1'b1;
    // single fetch
    req_i = 1'b1;
    addr_i = 32'h0000_1006;
    #3;
    chk("single_gnt", 64'(gnt_o), 64'd1);
    chk("single_addr", 64'(tl_o.a_address), 64'h1004);
    chk("single_src", 64'(tl_o.a_source), 64'd0);
    chk("single_mask", 64'(tl_o.a_mask), 64'hF);
    chk("single_op", 64'(tl_o.a_opcode), 64'd4);
    chk("single_size", 64'(tl_o.a_size), 64'd2);
    chk("single_dready", 64'(tl_o.d_ready), 64'd1);
    tick;
    req_i = 1'b0;
    dsend(8'd0, 32'hDEAD_BEEF, 3'd1, 1'b0, 1'b1, 1'b0);
    tick;
    // full stall
    fetch("stall_f0", 32'h100, 8'd1);
    fetch("stall_f1", 32'h104, 8'd0);
    req_i = 1'b1;
    addr_i = 32'h108;
    #3;
    chk("stall_avalid", 64'(tl_o.a_valid), 64'd0);
    chk("stall_gnt", 64'(gnt_o), 64'd0);
    tick;
    set_d(8'd1, 32'h1111_0100, 3'd1, 1'b0);
    exp_q.push_back({1'b0, 32'h1111_0100});
    #3;
    chk("stall_full_with_d", 64'(tl_o.a_valid), 64'd0);
    tick;
    clr_d;
    #3;
    chk("stall_freed_gnt", 64'(gnt_o), 64'd1);
    chk("stall_freed_src", 64'(tl_o.a_source), 64'd1);
    tick;
    req_i = 1'b0;
    dsend(8'd0, 32'h1111_0104, 3'd1, 1'b0, 1'b1, 1'b0);
    dsend(8'd1, 32'h1111_0108, 3'd1, 1'b0, 1'b1, 1'b0);
    // error responses
    fetch("err_op", 32'h300, 8'd0);
    dsend(8'd0, 32'h0000_0300, 3'd0, 1'b0, 1'b1, 1'b1);
    fetch("err_derr", 32'h304, 8'd1);
    dsend(8'd1, 32'h0000_0304, 3'd1, 1'b1, 1'b1, 1'b1);
    fetch("err_src", 32'h308, 8'd0);
    dsend(8'd1, 32'h0000_0308, 3'd1, 1'b0, 1'b1, 1'b1);
    // streaming: A and D every cycle, pending held at 1
    for (int i = 0; i <= 16; i++) begin
      req_i = (i < 16);
      addr_i = 32'h2000 + 32'(4 * i);
      if (i > 0) begin
        set_d(8'(i % 2), 32'h5000_0000 + 32'(i - 1), 3'd1, 1'b0);
        exp_q.push_back({1'b0, 32'h5000_0000 + 32'(i - 1)});
      end
      #3;
      if (i < 16) begin
        chk("stream_gnt", 64'(gnt_o), 64'd1);
        chk("stream_src", 64'(tl_o.a_source), 64'((1 + i) % 2));
      end
      tick;
      clr_d;
    end
    req_i = 1'b0;
`ifdef TLUL_FETCH_FLUSH_EN
    fetch("flush_f0", 32'h500, 8'd1);
    fetch("flush_f1", 32'h504, 8'd0);
    flush_i = 1'b1;
    tick;
    flush_i = 1'b0;
    dsend(8'd1, 32'hBAD0_0500, 3'd1, 1'b0, 1'b0, 1'b0);
    set_d(8'd0, 32'hBAD0_0504, 3'd1, 1'b0);
    req_i = 1'b1;
    addr_i = 32'h40;
    #3;
    chk("flush_new_gnt", 64'(gnt_o), 64'd1);
    chk("flush_new_addr", 64'(tl_o.a_address), 64'h40);
    chk("flush_new_src", 64'(tl_o.a_source), 64'd1);
    tick;
    clr_d;
    req_i = 1'b0;
    dsend(8'd1, 32'h0000_4040, 3'd1, 1'b0, 1'b1, 1'b0);
    tick;
`endif
    // reset mid-flight, then a late response
    req_i = 1'b1;
    addr_i = 32'h600;
    #3;
    chk("rstmid_gnt0", 64'(gnt_o), 64'd1);
    tick;
    addr_i = 32'h604;
    #3;
    chk("rstmid_gnt1", 64'(gnt_o), 64'd1);
    tick;
    req_i = 1'b0;
    reset = 1'b0;
    tick;
    reset = 1'b1;
    dsend(8'd0, 32'hBAD0_0600, 3'd1, 1'b0, 1'b0, 1'b0);
    #3;
    chk("late_d_rvalid", 64'(rvalid_o), 64'd0);
    tick;
    fetch("post_rst_f0", 32'h700, 8'd0);
    fetch("post_rst_f1", 32'h704, 8'd1);
    req_i = 1'b1;
    addr_i = 32'h708;
    #3;
    chk("post_rst_full", 64'(tl_o.a_valid), 64'd0);
    tick;
    req_i = 1'b0;
    dsend(8'd0, 32'h0000_0700, 3'd1, 1'b0, 1'b1, 1'b0);
    dsend(8'd1, 32'h0000_0704, 3'd1, 1'b0, 1'b1, 1'b0);
    repeat (3) tick;
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
